// File: rtl/mac_pkg.sv
// Shared definitions for the MAC forwarding block: header layout,
// port-mask constants and FSM state encodings.
package mac_pkg;

    localparam int MAC_W         = 48;
    localparam int FCS_BIT       = 115;
    localparam int CTRL_BIT      = 114;
    localparam int PORT_LO       = 112;
    localparam int DST_LO        = 64;
    localparam int SRC_LO        = 16;
    localparam int MAC_GROUP_BIT = 40;
    localparam int CPU_PORT_BIT  = 4;

    localparam logic [39:0] CTRL_PREFIX = 40'h01_80_C2_00_00;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_LOOKUP = 3'd2;
    localparam logic [2:0] S_DESC   = 3'd3;
    localparam logic [2:0] S_BODY   = 3'd4;
    localparam logic [2:0] S_DROP   = 3'd5;

    typedef logic [4:0] port_mask_t;

    typedef struct packed {
        logic              fcs_ok;
        logic              ctrl;
        logic [1:0]        port;
        logic [MAC_W-1:0]  dst;
        logic [MAC_W-1:0]  src;
    } hdr_t;

    function automatic hdr_t hdr_fields(input logic [127:0] w);
        hdr_t h;
        h.fcs_ok = w[FCS_BIT];
        h.ctrl   = w[CTRL_BIT];
        h.port   = w[PORT_LO +: 2];
        h.dst    = w[DST_LO +: MAC_W];
        h.src    = w[SRC_LO +: MAC_W];
        return h;
    endfunction

    // All front-panel ports except the one the frame came in on
    function automatic port_mask_t flood_mask(input logic [1:0] p);
        port_mask_t m;
        m    = 5'b01111;
        m[p] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/mac_table.sv
// MAC learning table: parallel DST/SRC match, learn port, victim pointer.
// Define MAC_FWD_AGING_EN to age entries out every AGE_TICK cycles.
module mac_table
    import mac_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [23:0] AGE_TICK = 24'd1_000_000
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cmp_en,
    input  logic [MAC_W-1:0] dst_mac,
    input  logic [MAC_W-1:0] src_mac,
    input  logic             learn_en,
    input  logic [1:0]       learn_port,
    output logic             dst_hit,
    output logic [1:0]       dst_port
);

    localparam int IW = $clog2(DEPTH);

    logic [MAC_W-1:0] mac [DEPTH];
    logic [1:0]       prt [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [IW-1:0]    victim;
    logic             src_hit;
    logic [IW-1:0]    src_idx;

    logic             d_any, s_any, free_any;
    logic [IW-1:0]    d_idx, s_idx, free_idx, wr_idx;

    always_comb begin
        d_any    = 1'b0;
        s_any    = 1'b0;
        free_any = 1'b0;
        d_idx    = '0;
        s_idx    = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld[i] && mac[i] == dst_mac) begin
                d_any = 1'b1;
                d_idx = IW'(i);
            end
            if (vld[i] && mac[i] == src_mac) begin
                s_any = 1'b1;
                s_idx = IW'(i);
            end
            if (!vld[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign wr_idx = src_hit  ? src_idx :
                    free_any ? free_idx : victim;

`ifdef MAC_FWD_AGING_EN
    logic [1:0]  age [DEPTH];
    logic [23:0] tick_cnt;
    logic        tick;

    assign tick = (tick_cnt == AGE_TICK - 24'd1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) tick_cnt <= '0;
        else         tick_cnt <= tick ? '0 : tick_cnt + 24'd1;
    end
`else
    logic unused_tick;
    assign unused_tick = ^AGE_TICK;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mac[i] <= '0;
                prt[i] <= '0;
`ifdef MAC_FWD_AGING_EN
                age[i] <= '0;
`endif
            end
            vld      <= '0;
            victim   <= '0;
            src_hit  <= 1'b0;
            src_idx  <= '0;
            dst_hit  <= 1'b0;
            dst_port <= '0;
        end else begin
            if (cmp_en) begin
                dst_hit  <= d_any;
                dst_port <= prt[d_idx];
                src_hit  <= s_any;
                src_idx  <= s_idx;
            end
`ifdef MAC_FWD_AGING_EN
            // The entry being learned keeps its fresh state this cycle
            if (tick) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (vld[i] && !(learn_en && wr_idx == IW'(i))) begin
                        if (age[i] == 2'd3) vld[i] <= 1'b0;
                        else                age[i] <= age[i] + 2'd1;
                    end
                end
            end
`endif
            if (learn_en) begin
                mac[wr_idx] <= src_mac;
                prt[wr_idx] <= learn_port;
                vld[wr_idx] <= 1'b1;
`ifdef MAC_FWD_AGING_EN
                age[wr_idx] <= 2'd0;
`endif
                if (!src_hit && !free_any) victim <= victim + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_fwd.sv
// Learning MAC forwarder: header lookup, descriptor emit, body copy/drop.
// Optional entry aging is enabled with MAC_FWD_AGING_EN.
module mac_fwd
    import mac_pkg::*;
#(
    parameter int          TABLE_DEPTH = 16,
    parameter logic [23:0] AGE_TICK    = 24'd1_000_000
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [127:0] h_fifo_dout,
    input  logic         h_fifo_empty,
    output logic         h_fifo_rden,
    input  logic [7:0]   b_fifo_dout,
    input  logic         b_fifo_del,
    input  logic         b_fifo_empty,
    output logic         b_fifo_rden,
    output logic [7:0]   d_fifo_din,
    input  logic         d_fifo_full,
    output logic         d_fifo_wren,
    output logic [7:0]   o_fifo_din,
    output logic         o_fifo_del,
    input  logic         o_fifo_afull,
    output logic         o_fifo_wren
);

    logic [2:0]  state;
    hdr_t        hdr;
    port_mask_t  mask_q;
    port_mask_t  mask;
    logic        drop;
    logic        run_q;
    logic        dst_hit;
    logic [1:0]  dst_port;
    logic        learn_en;
    logic        fwd_pop;
    logic        drop_pop;

    logic unused_bits;
    assign unused_bits = ^{h_fifo_dout[127:116], h_fifo_dout[15:0]};

    // run_q keeps the header pop quiet while reset is held
    assign h_fifo_rden = run_q && (state == S_IDLE) && !h_fifo_empty;
    assign d_fifo_wren = (state == S_DESC) && !d_fifo_full;
    assign d_fifo_din  = {3'b000, mask_q};
    assign fwd_pop     = (state == S_BODY) && !b_fifo_empty && !o_fifo_afull;
    assign drop_pop    = (state == S_DROP) && !b_fifo_empty;
    assign b_fifo_rden = fwd_pop || drop_pop;
    assign learn_en    = (state == S_LOOKUP) && hdr.fcs_ok
                         && !hdr.src[MAC_GROUP_BIT];

    always_comb begin
        drop = 1'b0;
        mask = '0;
        if (!hdr.fcs_ok) begin
            drop = 1'b1;
        end else if (hdr.ctrl || hdr.dst[47:8] == CTRL_PREFIX) begin
            mask = port_mask_t'(1) << CPU_PORT_BIT;
        end else if (hdr.dst[MAC_GROUP_BIT] || !dst_hit) begin
            mask = flood_mask(hdr.port);
        end else if (dst_port == hdr.port) begin
            drop = 1'b1;
        end else begin
            mask = port_mask_t'(1) << dst_port;
        end
    end

    mac_table #(
        .DEPTH    (TABLE_DEPTH),
        .AGE_TICK (AGE_TICK)
    ) u_table (
        .clk        (clk),
        .arst_n     (arst_n),
        .cmp_en     (state == S_HDR),
        .dst_mac    (hdr.dst),
        .src_mac    (hdr.src),
        .learn_en   (learn_en),
        .learn_port (hdr.port),
        .dst_hit    (dst_hit),
        .dst_port   (dst_port)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            hdr         <= '0;
            mask_q      <= '0;
            run_q       <= 1'b0;
            o_fifo_din  <= '0;
            o_fifo_del  <= 1'b0;
            o_fifo_wren <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            o_fifo_wren <= fwd_pop;
            if (fwd_pop) begin
                o_fifo_din <= b_fifo_dout;
                o_fifo_del <= b_fifo_del;
            end
            case (state)
                S_IDLE: begin
                    if (h_fifo_rden) begin
                        hdr   <= hdr_fields(h_fifo_dout);
                        state <= S_HDR;
                    end
                end
                S_HDR: state <= S_LOOKUP;
                S_LOOKUP: begin
                    if (drop) begin
                        state <= S_DROP;
                    end else begin
                        mask_q <= mask;
                        state  <= S_DESC;
                    end
                end
                S_DESC: begin
                    if (d_fifo_wren) state <= S_BODY;
                end
                S_BODY, S_DROP: begin
                    if (b_fifo_rden && b_fifo_del) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_fwd.sv
// Self-checking bench for mac_fwd: queue-modelled FIFOs, behavioural
// forwarding/learning model, directed frames plus random traffic.
module tb_mac_fwd;

    localparam int DEPTH = 16;
`ifdef MAC_FWD_AGING_EN
    localparam logic [23:0] TICK = 24'd16;
`else
    localparam logic [23:0] TICK = 24'd1_000_000;
`endif

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic [127:0] h_fifo_dout = '0;
    logic         h_fifo_empty = 1'b1;
    logic         h_fifo_rden;
    logic [7:0]   b_fifo_dout = '0;
    logic         b_fifo_del = 1'b0;
    logic         b_fifo_empty = 1'b1;
    logic         b_fifo_rden;
    logic [7:0]   d_fifo_din;
    logic         d_fifo_full = 1'b0;
    logic         d_fifo_wren;
    logic [7:0]   o_fifo_din;
    logic         o_fifo_del;
    logic         o_fifo_afull = 1'b0;
    logic         o_fifo_wren;

    always #5 clk = ~clk;

    mac_fwd #(
        .TABLE_DEPTH (DEPTH),
        .AGE_TICK    (TICK)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .h_fifo_dout  (h_fifo_dout),
        .h_fifo_empty (h_fifo_empty),
        .h_fifo_rden  (h_fifo_rden),
        .b_fifo_dout  (b_fifo_dout),
        .b_fifo_del   (b_fifo_del),
        .b_fifo_empty (b_fifo_empty),
        .b_fifo_rden  (b_fifo_rden),
        .d_fifo_din   (d_fifo_din),
        .d_fifo_full  (d_fifo_full),
        .d_fifo_wren  (d_fifo_wren),
        .o_fifo_din   (o_fifo_din),
        .o_fifo_del   (o_fifo_del),
        .o_fifo_afull (o_fifo_afull),
        .o_fifo_wren  (o_fifo_wren)
    );

    int ncmp = 0;
    int nerr = 0;
    int o_cnt = 0;
    int cyc = 0;
    int hcyc = 0;
    bit full_seen = 1'b1;
    bit rnd = 1'b0;

    logic [127:0] hq[$];
    logic [8:0]   bq[$];
    int           exp_d[$];
    logic [8:0]   exp_o[$];

    logic [47:0] m_mac [DEPTH];
    logic [1:0]  m_port [DEPTH];
    bit          m_vld [DEPTH];
    int          m_vict = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Forwarding decision from the rules, then learning; -1 means drop
    function automatic int model_frame(bit fcs, bit ctrl, logic [1:0] p,
                                       logic [47:0] dst, logic [47:0] src);
        int res;
        int hit;
        int s;
        int f;
        hit = -1;
        for (int i = 0; i < DEPTH; i++)
            if (hit < 0 && m_vld[i] && m_mac[i] == dst) hit = i;
        if (!fcs) res = -1;
        else if (ctrl || dst[47:8] == 40'h0180C20000) res = 16;
        else if (dst[40] || hit < 0) res = 15 & ~(1 << p);
        else if (m_port[hit] == p) res = -1;
        else res = 1 << m_port[hit];
        if (fcs && !src[40]) begin
            s = -1;
            f = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (s < 0 && m_vld[i] && m_mac[i] == src) s = i;
                if (f < 0 && !m_vld[i]) f = i;
            end
            if (s < 0) begin
                if (f >= 0) s = f;
                else begin
                    s = m_vict;
                    m_vict = (m_vict + 1) % DEPTH;
                end
            end
            m_mac[s] = src;
            m_port[s] = p;
            m_vld[s] = 1'b1;
        end
        return res;
    endfunction

    task automatic send(input logic [1:0] p, input logic [47:0] dst,
                        input logic [47:0] src, input bit fcs, input bit ctrl,
                        input int len, output int res);
        logic [127:0] h;
        logic [8:0] b;
        h = {12'h000, fcs, ctrl, p, dst, src, 16'h0800};
        res = model_frame(fcs, ctrl, p, dst, src);
        hq.push_back(h);
        for (int i = 0; i < len; i++) begin
            b = {i == len - 1, 8'($urandom)};
            bq.push_back(b);
            if (res >= 0) exp_o.push_back(b);
        end
        if (res >= 0) exp_d.push_back(res);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((hq.size() != 0 || bq.size() != 0 || exp_d.size() != 0
                || exp_o.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        chk({tag, "_timeout"}, 64'(n >= 5000), 0);
        chk({tag, "_desc_left"}, exp_d.size(), 0);
        chk({tag, "_body_left"}, exp_o.size() + bq.size(), 0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        hq.delete();
        bq.delete();
        exp_d.delete();
        exp_o.delete();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_vict = 0;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_h_rden"}, h_fifo_rden, 0);
        chk({tag, "_b_rden"}, b_fifo_rden, 0);
        chk({tag, "_d_wren"}, d_fifo_wren, 0);
        chk({tag, "_d_din"}, d_fifo_din, 0);
        chk({tag, "_o_wren"}, o_fifo_wren, 0);
        chk({tag, "_o_din"}, o_fifo_din, 0);
        chk({tag, "_o_del"}, o_fifo_del, 0);
    endtask

    // FIFO side: decisions seen at negedge take effect at the posedge
    always begin
        bit hr;
        bit br;
        @(negedge clk);
        hr = h_fifo_rden && arst_n;
        br = b_fifo_rden && arst_n;
        @(posedge clk);
        #1;
        if (hr && hq.size() > 0) void'(hq.pop_front());
        if (br && bq.size() > 0) void'(bq.pop_front());
        h_fifo_empty = (hq.size() == 0);
        h_fifo_dout  = (hq.size() == 0) ? '0 : hq[0];
        b_fifo_empty = (bq.size() == 0) || (rnd && $urandom_range(7) == 0);
        {b_fifo_del, b_fifo_dout} = (bq.size() == 0) ? 9'h0 : bq[0];
        o_fifo_afull = rnd && $urandom_range(3) == 0;
        d_fifo_full  = rnd && $urandom_range(5) == 0;
    end

    always @(negedge clk) begin
        int e;
        cyc++;
        if (arst_n) begin
            if (h_fifo_rden) begin
                hcyc = cyc;
                full_seen = 1'b0;
            end
            if (d_fifo_full) full_seen = 1'b1;
            if (d_fifo_wren) begin
                if (exp_d.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL desc_unexpected: got %0h expected none",
                             d_fifo_din);
                end else begin
                    e = exp_d.pop_front();
                    chk("desc", d_fifo_din, 64'(e));
                end
                if (!full_seen) chk("desc_latency", cyc - hcyc, 3);
            end
            if (o_fifo_wren) begin
                o_cnt++;
                if (exp_o.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL body_unexpected: got %0h expected none",
                             {o_fifo_del, o_fifo_din});
                end else begin
                    chk("body", {o_fifo_del, o_fifo_din}, exp_o.pop_front());
                end
            end
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int c0;
        int n;
        logic [47:0] pool [24];
        logic [47:0] dst;
        logic [47:0] src;
        for (int i = 0; i < 24; i++) pool[i] = 48'h0060_0000_0000 + 48'(i);

        #3;
        chk_outs_zero("reset");
        do_reset();
        @(negedge clk);

`ifdef MAC_FWD_AGING_EN
        send(2, 48'hFFFF_FFFF_FFFF, 48'h00AA_0000_0001, 1, 0, 4, r);
        chk("model_age_learn", r, 64'h0B);
        drain("age_learn");
        repeat (100) @(posedge clk);
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        send(0, 48'h00AA_0000_0001, 48'h00BB_0000_0002, 1, 0, 4, r);
        chk("model_age_flood", r, 64'h0E);
        drain("age_flood");
`else
        c0 = o_cnt;
        send(2, 48'h0011_2233_4455, 48'h00AA_0000_0001, 1, 0, 60, r);
        chk("model_f027", r, 64'h0B);
        drain("f027");
        chk("bytes_f027", o_cnt - c0, 60);

        send(0, 48'h00AA_0000_0001, 48'h00BB_0000_0002, 1, 0, 8, r);
        chk("model_f028", r, 64'h04);
        drain("f028");

        c0 = o_cnt;
        send(2, 48'h00AA_0000_0001, 48'h00CC_0000_0003, 1, 0, 12, r);
        chk("model_f029", r, -1);
        drain("f029");
        chk("bytes_f029", o_cnt - c0, 0);

        send(3, 48'h00DD_0000_0000, 48'h00EE_0000_0004, 0, 0, 10, r);
        chk("model_fcs_bad", r, -1);
        send(1, 48'h00EE_0000_0004, 48'h0011_0000_0005, 1, 0, 6, r);
        chk("model_not_learned", r, 64'h0D);
        send(0, 48'h0180_C200_0001, 48'h0022_0000_0006, 1, 0, 6, r);
        chk("model_ctrl_addr", r, 64'h10);
        send(1, 48'h00AA_0000_0001, 48'h0033_0000_0007, 1, 1, 4, r);
        chk("model_ctrl_bit", r, 64'h10);
        drain("f030");

        do_reset();
        rnd = 1'b1;
        for (int k = 0; k <= DEPTH; k++) begin
            send(1, 48'hFFFF_FFFF_FFFF, 48'h0050_0000_0000 + 48'(k),
                 1, 0, 3 + k % 4, r);
            if (k == 0) chk("model_fill", r, 64'h0D);
        end
        send(3, 48'h0050_0000_0000, 48'h0100_0000_0077, 1, 0, 5, r);
        chk("model_evicted", r, 64'h07);
        send(3, 48'h0050_0000_0001, 48'h0100_0000_0077, 1, 0, 5, r);
        chk("model_kept", r, 64'h02);
        drain("f031");
        rnd = 1'b0;

        send(3, 48'hFFFF_FFFF_FFFF, 48'h00AB_0000_0009, 1, 0, 40, r);
        n = 0;
        while (!o_fifo_wren && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_reached_body", 64'(n >= 200), 0);
        #2;
        arst_n = 1'b0;
        #1;
        chk_outs_zero("midreset");
        do_reset();
        @(negedge clk);
        send(0, 48'h00AB_0000_0009, 48'h00AC_0000_000A, 1, 0, 4, r);
        chk("model_after_reset", r, 64'h0E);
        drain("after_reset");

        rnd = 1'b1;
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(19))
                0, 1:    dst = 48'hFFFF_FFFF_FFFF;
                2:       dst = {40'h0180C20000, 8'($urandom)};
                default: dst = pool[$urandom_range(23)];
            endcase
            if ($urandom_range(19) == 0) src = 48'h0100_0000_0000 + 48'(f);
            else                         src = pool[$urandom_range(23)];
            send(2'($urandom_range(3)), dst, src,
                 $urandom_range(9) != 0, $urandom_range(19) == 0,
                 $urandom_range(1, 16), r);
        end
        drain("random");
        rnd = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/mac_fwd.md
MAC_FWD -- requirements
Module: mac_fwd

Interface
REQ-001 SHALL have parameter TABLE_DEPTH, default 16, meaning number of MAC learning-table entries (power of two, 4..32).
REQ-002 SHALL have parameter AGE_TICK, default 24'd1_000_000, meaning clk cycles per aging tick.
REQ-003 SHALL have ports as follows: clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port arst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port h_fifo_dout  in  128  header word {RSVD[11:0], FCS_OK[115], CTRL[114], PORT[113:112], DST[111:64], SRC[63:16], TYPE[15:0]}.
REQ-006 SHALL have ports h_fifo_empty  in  1, and h_fifo_rden  out  1  (header FIFO, first-word-fall-through: dout valid while !empty, rden pops).
REQ-007 SHALL have ports b_fifo_dout  in  8, b_fifo_del  in  1 (last byte of frame), b_fifo_empty  in  1, and b_fifo_rden  out  1 (body FIFO, first-word-fall-through).
REQ-008 SHALL have ports d_fifo_din  out  8 ({3'b0, port_mask[4:0]}, bit4 = CPU), d_fifo_full  in  1, and d_fifo_wren  out  1 (descriptor FIFO).
REQ-009 SHALL have ports o_fifo_din  out  8, o_fifo_del  out  1, o_fifo_afull  in  1, and o_fifo_wren  out  1 (forwarded body FIFO).

Function
REQ-010 SHALL implement FSM states S_IDLE, S_HDR, S_LOOKUP, S_DESC, S_BODY, S_DROP; undefined state SHALL go to S_IDLE.
REQ-011 In S_IDLE with !h_fifo_empty, SHALL assert h_fifo_rden for one cycle, latch the header, and go to S_HDR.
REQ-012 In S_HDR, SHALL compare DST and SRC against all valid entries in parallel in one cycle, then go to S_LOOKUP.
REQ-013 In S_LOOKUP, SHALL compute port_mask by priority: FCS_OK=0 -> drop; CTRL=1 or DST[111:72]==40'h01_80_C2_00_00 -> 5'b10000; DST group bit (DST[104]) set, or DST missing from the table -> 5'b01111 with the ingress bit cleared; DST hit with entry port == ingress -> drop; otherwise one-hot of the entry port.
REQ-014 Drop SHALL go to S_DROP with no descriptor written; all other outcomes SHALL go to S_DESC.
REQ-015 Learning SHALL occur in S_LOOKUP only when FCS_OK=1 and SRC group bit (SRC[56])=0: on SRC hit, overwrite the entry port and clear its age; on miss, write the lowest-index invalid entry, or if none, the entry at victim pointer, then increment the pointer modulo TABLE_DEPTH.
REQ-016 S_DESC SHALL hold until !d_fifo_full, then pulse d_fifo_wren with d_fifo_din and go to S_BODY; descriptor lands exactly 3 cycles after the header pop when the FIFO is not full.
REQ-017 S_BODY SHALL pop b_fifo and register the byte to o_fifo_din/o_fifo_del/o_fifo_wren (1-cycle latency) each cycle that !b_fifo_empty && !o_fifo_afull; otherwise it SHALL stall with wren=0.
REQ-018 S_DROP SHALL pop b_fifo each cycle that !b_fifo_empty, with o_fifo_wren=0.
REQ-019 In S_BODY and S_DROP, popping a byte with b_fifo_del=1 SHALL go to S_IDLE; the next header SHALL NOT be popped in that same cycle.
REQ-020 A learn and a lookup of the same MAC in one frame SHALL use the pre-learn table contents.

Reset
REQ-021 On arst_n=0, SHALL asynchronously set state S_IDLE, all valid bits 0, victim pointer 0, age counters 0, and all outputs (rden, wren, din, del) 0.
REQ-022 Reset mid-frame SHALL abandon the frame; upstream/downstream FIFOs SHALL be reset by the same arst_n.

Configuration
REQ-023 Macro MAC_FWD_AGING_EN SHALL, when defined, give each entry a 2-bit age that increments per AGE_TICK, with the entry invalidated when a tick arrives at age 3; aging SHALL NOT alter an entry being learned that cycle.
REQ-024 Without MAC_FWD_AGING_EN, entries SHALL persist until overwritten or reset, and no tick counter SHALL exist.

Structure
REQ-025 Shared package mac_pkg SHALL hold the header bit-field offsets, CPU_PORT_BIT=4, the control-address prefix, and the FSM state encodings.
REQ-026 Learning table SHALL be sub-module mac_table (parallel match, learn port, victim pointer, optional aging); FSM and datapath SHALL stay in mac_fwd.

Verification
REQ-027 Empty table, frame from port 2 with DST 00:11:22:33:44:55 and SRC 00:AA:00:00:00:01, 60 bytes -> descriptor 0x0B, 60 bytes out with del on the last, SRC learned on port 2.
REQ-028 Following the REQ-027 frame, a frame from port 0 with DST 00:AA:00:00:00:01 -> descriptor 0x04.
REQ-029 Frame from port 2 with DST 00:AA:00:00:00:01 (known on port 2) -> no descriptor, body drained, no output writes.
REQ-030 FCS_OK=0 -> no descriptor, SRC not learned; DST 01:80:C2:00:00:01 with FCS_OK=1 -> descriptor 0x10.
REQ-031 TABLE_DEPTH+1 distinct SRCs -> entry 0 replaced; o_fifo_afull toggled mid-body -> no byte lost or duplicated.
REQ-032 With MAC_FWD_AGING_EN and AGE_TICK=16, no refresh for 64 cycles -> entry invalid, next lookup floods; arst_n pulsed mid-body -> all outputs 0 and table empty.
